// File: rtl/ring_rx_decoder_if.sv
// Bundles the serial ring input and the decoded-packet handshake of ring_rx_decoder.
// The master modport is the driving side (ring and control FSM), and the slave modport is the decoder.
interface ring_rx_decoder_if #(
    parameter int PAYLOAD_W = 16
);
    logic                 Rx_In;
    logic                 Rx_Valid;
    logic                 rc_ready;
    logic                 rx_has_data;
    logic [2:0]           data_type;
    logic [3:0]           address;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic                 bad_decode;
    logic                 rx_overrun;
    logic                 rx_abort;

    modport master (
        output Rx_In, Rx_Valid, rc_ready,
        input  rx_has_data, data_type, address, rx_payload,
        input  bad_decode, rx_overrun, rx_abort
    );

    modport slave (
        input  Rx_In, Rx_Valid, rc_ready,
        output rx_has_data, data_type, address, rx_payload,
        output bad_decode, rx_overrun, rx_abort
    );
endinterface

// File: rtl/ring_rx_decoder.sv
// Token-ring receive deserialiser with parity/stop check and a one-entry holding register.
// Optional macro RX_TIMEOUT_EN enables the inter-strobe timeout that abandons a stalled frame.
module ring_rx_decoder #(
    parameter int PAYLOAD_W   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   Clk_R,
    input  logic                   Rst_n,
    ring_rx_decoder_if.slave       bus
);
    // Bits after the start bit and before the stop bit: type, address, payload, parity.
    localparam int BODY_W = 7 + PAYLOAD_W + 1;
    localparam int CNT_W  = $clog2(PAYLOAD_W + 10);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BODY_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BODY_W-1:0]    shift_q;
    logic                 has_q;
    logic [2:0]           type_q;
    logic [3:0]           addr_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 bad_q;
    logic                 overrun_q;

    logic frame_done;
    logic frame_bad;

    assign frame_done = (state_q == STOP) && bus.Rx_Valid;
    // Even parity over body including parity bit means the XOR of the body must be zero.
    assign frame_bad  = (^shift_q) | bus.Rx_In;

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             abort_q;
`endif

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            has_q     <= 1'b0;
            type_q    <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            bad_q     <= 1'b0;
            overrun_q <= 1'b0;
`ifdef RX_TIMEOUT_EN
            tmo_q     <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
`ifdef RX_TIMEOUT_EN
            abort_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.Rx_Valid && bus.Rx_In) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (bus.Rx_Valid) begin
                        shift_q <= {shift_q[BODY_W-2:0], bus.Rx_In};
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bus.Rx_Valid) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A consume on the completion edge frees the slot for the new frame.
            if (frame_done) begin
                if (!has_q || bus.rc_ready) begin
                    has_q     <= 1'b1;
                    type_q    <= shift_q[BODY_W-1 -: 3];
                    addr_q    <= shift_q[BODY_W-4 -: 4];
                    payload_q <= shift_q[PAYLOAD_W:1];
                    bad_q     <= frame_bad;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (has_q && bus.rc_ready) begin
                has_q <= 1'b0;
            end

`ifdef RX_TIMEOUT_EN
            if (state_q == IDLE || bus.Rx_Valid) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                tmo_q   <= '0;
                abort_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

    assign bus.rx_has_data = has_q;
    assign bus.data_type   = type_q;
    assign bus.address     = addr_q;
    assign bus.rx_payload  = payload_q;
    assign bus.bad_decode  = bad_q;
    assign bus.rx_overrun  = overrun_q;
`ifdef RX_TIMEOUT_EN
    assign bus.rx_abort    = abort_q;
`else
    assign bus.rx_abort    = 1'b0;
`endif
endmodule

// File: tb/tb_ring_rx_decoder.sv
// Directed bench for ring_rx_decoder: decode, parity/stop errors, overrun, gaps, mid-frame reset, stall.
// Frames are built MSB-first as {start, type, addr, payload, parity, stop}.
module tb_ring_rx_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ring_rx_decoder_if #(.PAYLOAD_W(16)) bus ();

    ring_rx_decoder #(.PAYLOAD_W(16), .TIMEOUT_CYC(64)) dut (
        .Clk_R (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] mk_frame(input logic [2:0] t, input logic [3:0] a,
                                             input logic [15:0] p, input bit flip_par,
                                             input logic stop_b);
        logic par;
        par = (^{t, a, p}) ^ flip_par;
        return {1'b1, t, a, p, par, stop_b};
    endfunction

    // Sends bits f[hi] down to f[lo]; rc_ready is raised only with the final stop strobe if rdy_stop.
    task automatic send_bits(input logic [25:0] f, input int hi, input int lo,
                             input int gap_max, input bit rdy_stop);
        for (int i = hi; i >= lo; i--) begin
            bus.Rx_Valid = 1'b1;
            bus.Rx_In    = f[i];
            bus.rc_ready = (i == 0) && rdy_stop;
            tick();
            bus.Rx_Valid = 1'b0;
            bus.Rx_In    = 1'b0;
            bus.rc_ready = 1'b0;
            if (i != lo) begin
                int g;
                g = int'($urandom_range(0, gap_max));
                repeat (g) tick();
            end
        end
    endtask

    task automatic consume(input string tag);
        bus.rc_ready = 1'b1;
        tick();
        bus.rc_ready = 1'b0;
        chk(tag, 32'(bus.rx_has_data), 32'd0);
    endtask

    initial begin
        logic [25:0] f;
        int          aborts;
        bus.Rx_In    = 1'b0;
        bus.Rx_Valid = 1'b0;
        bus.rc_ready = 1'b0;
        repeat (2) tick();
        chk("rst_has",     32'(bus.rx_has_data), 32'd0);
        chk("rst_type",    32'(bus.data_type),   32'd0);
        chk("rst_addr",    32'(bus.address),     32'd0);
        chk("rst_payload", 32'(bus.rx_payload),  32'd0);
        chk("rst_bad",     32'(bus.bad_decode),  32'd0);
        chk("rst_overrun", 32'(bus.rx_overrun),  32'd0);
        chk("rst_abort",   32'(bus.rx_abort),    32'd0);
        rst_n = 1'b1;
        tick();

        // DATA_C, back-to-back
        f = mk_frame(3'b010, 4'b0001, 16'hA5A5, 1'b0, 1'b0);
        send_bits(f, 25, 1, 0, 1'b0);
        chk("dc_has_before_stop", 32'(bus.rx_has_data), 32'd0);
        send_bits(f, 0, 0, 0, 1'b0);
        chk("dc_has",     32'(bus.rx_has_data), 32'd1);
        chk("dc_type",    32'(bus.data_type),   32'd2);
        chk("dc_addr",    32'(bus.address),     32'd1);
        chk("dc_payload", 32'(bus.rx_payload),  32'hA5A5);
        chk("dc_bad",     32'(bus.bad_decode),  32'd0);
        consume("dc_consumed");

        // parity flipped
        f = mk_frame(3'b010, 4'b0001, 16'hA5A5, 1'b1, 1'b0);
        send_bits(f, 25, 0, 0, 1'b0);
        chk("par_bad",     32'(bus.bad_decode), 32'd1);
        chk("par_payload", 32'(bus.rx_payload), 32'hA5A5);
        consume("par_consumed");

        // stop bit 1
        f = mk_frame(3'b010, 4'b0001, 16'hA5A5, 1'b0, 1'b1);
        send_bits(f, 25, 0, 0, 1'b0);
        chk("stop_bad",  32'(bus.bad_decode), 32'd1);
        chk("stop_addr", 32'(bus.address),    32'd1);
        consume("stop_consumed");

        // TOKEN held, ACK dropped
        f = mk_frame(3'b111, 4'b0000, 16'h0000, 1'b0, 1'b0);
        send_bits(f, 25, 0, 0, 1'b0);
        chk("tok_type", 32'(bus.data_type), 32'd7);
        f = mk_frame(3'b000, 4'b0101, 16'h00FF, 1'b0, 1'b0);
        send_bits(f, 25, 0, 0, 1'b0);
        chk("ovr_pulse",    32'(bus.rx_overrun), 32'd1);
        chk("ovr_tok_type", 32'(bus.data_type),  32'd7);
        chk("ovr_tok_addr", 32'(bus.address),    32'd0);
        tick();
        chk("ovr_pulse_end", 32'(bus.rx_overrun),  32'd0);
        chk("ovr_has",       32'(bus.rx_has_data), 32'd1);

        // ACK completes on the consume edge
        send_bits(f, 25, 0, 0, 1'b1);
        chk("ack_has",     32'(bus.rx_has_data), 32'd1);
        chk("ack_type",    32'(bus.data_type),   32'd0);
        chk("ack_addr",    32'(bus.address),     32'd5);
        chk("ack_payload", 32'(bus.rx_payload),  32'h00FF);
        chk("ack_no_ovr",  32'(bus.rx_overrun),  32'd0);
        tick();
        chk("ack_still_held", 32'(bus.rx_has_data), 32'd1);
        consume("ack_consumed");

        // DATA_3 with random gaps
        f = mk_frame(3'b001, 4'b0011, 16'h1234, 1'b0, 1'b0);
        send_bits(f, 25, 0, 5, 1'b0);
        chk("d3_has",     32'(bus.rx_has_data), 32'd1);
        chk("d3_type",    32'(bus.data_type),   32'd1);
        chk("d3_addr",    32'(bus.address),     32'd3);
        chk("d3_payload", 32'(bus.rx_payload),  32'h1234);
        chk("d3_bad",     32'(bus.bad_decode),  32'd0);

        // reset after 10 bits of a frame, with a packet still held
        f = mk_frame(3'b010, 4'b1111, 16'hFFFF, 1'b1, 1'b1);
        send_bits(f, 25, 16, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mr_has",     32'(bus.rx_has_data), 32'd0);
        chk("mr_type",    32'(bus.data_type),   32'd0);
        chk("mr_payload", 32'(bus.rx_payload),  32'd0);
        chk("mr_bad",     32'(bus.bad_decode),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        f = mk_frame(3'b011, 4'b1010, 16'hBEEF, 1'b0, 1'b0);
        send_bits(f, 25, 0, 0, 1'b0);
        chk("nack_type",    32'(bus.data_type),  32'd3);
        chk("nack_addr",    32'(bus.address),    32'hA);
        chk("nack_payload", 32'(bus.rx_payload), 32'hBEEF);
        chk("nack_bad",     32'(bus.bad_decode), 32'd0);
        consume("nack_consumed");

        // stall after 12 bits
        f = mk_frame(3'b010, 4'b0110, 16'h0F0F, 1'b0, 1'b0);
        send_bits(f, 25, 14, 0, 1'b0);
        aborts = 0;
`ifdef RX_TIMEOUT_EN
        for (int c = 0; c < 90; c++) begin
            tick();
            if (bus.rx_abort) aborts++;
        end
        chk("tmo_abort_count", 32'(aborts), 32'd1);
        chk("tmo_has",         32'(bus.rx_has_data), 32'd0);
        send_bits(f, 25, 0, 0, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.rx_abort) aborts++;
        end
        chk("gap_no_abort", 32'(aborts), 32'd0);
        chk("gap_has",      32'(bus.rx_has_data), 32'd0);
        send_bits(f, 13, 0, 0, 1'b0);
`endif
        chk("late_has",     32'(bus.rx_has_data), 32'd1);
        chk("late_type",    32'(bus.data_type),   32'd2);
        chk("late_addr",    32'(bus.address),     32'd6);
        chk("late_payload", 32'(bus.rx_payload),  32'h0F0F);
        chk("late_bad",     32'(bus.bad_decode),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
